// File: rtl/maze_pkg.sv
// Shared direction encoding, movement state type and direction helpers
// for the maze movement controller.
package maze_pkg;

    localparam int POS_W = 10;

    localparam logic [3:0] DIR_NONE = 4'b0000;
    localparam logic [3:0] DIR_L    = 4'b1000;
    localparam logic [3:0] DIR_R    = 4'b0100;
    localparam logic [3:0] DIR_U    = 4'b0010;
    localparam logic [3:0] DIR_D    = 4'b0001;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_MOVE = 1'b1
    } state_e;

    function automatic logic [3:0] dir_opposite(input logic [3:0] d);
        case (d)
            DIR_L:   return DIR_R;
            DIR_R:   return DIR_L;
            DIR_U:   return DIR_D;
            DIR_D:   return DIR_U;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/maze_move_ctrl_if.sv
// Control/observation bundle for maze_move_ctrl: movement strobes, table
// write port and the sprite position/status outputs.
interface maze_move_if #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8
);
    localparam int AW = $clog2(GRID_W * GRID_H);

    logic                           tick;
    logic [3:0]                     dir_req;
    logic                           start;
    logic                           tbl_we;
    logic [AW-1:0]                  tbl_addr;
    logic [3:0]                     tbl_data;
    logic [maze_pkg::POS_W-1:0]     xpos;
    logic [maze_pkg::POS_W-1:0]     ypos;
    logic [3:0]                     cur_dir;
    logic                           moving;
    logic [3:0]                     legal;
    logic                           at_center;

    modport master (
        output tick, dir_req, start, tbl_we, tbl_addr, tbl_data,
        input  xpos, ypos, cur_dir, moving, legal, at_center
    );

    modport slave (
        input  tick, dir_req, start, tbl_we, tbl_addr, tbl_data,
        output xpos, ypos, cur_dir, moving, legal, at_center
    );

endinterface

// File: rtl/maze_legal_tbl.sv
// Per-tile legal-direction table with combinational lookup of the tile
// under the sprite's top-left pixel.
module maze_legal_tbl
    import maze_pkg::*;
#(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int TILE_PX = 32,
    localparam int N      = GRID_W * GRID_H,
    localparam int AW     = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [3:0]       wdata_i,
    input  logic [POS_W-1:0] xpos_i,
    input  logic [POS_W-1:0] ypos_i,
    output logic [3:0]       legal_o
);
    localparam int SH = $clog2(TILE_PX);

    logic [N-1:0][3:0] tbl_q;
    logic [POS_W-1:0]  tx, ty;
    logic [31:0]       idx_full;
    logic [AW-1:0]     idx;

    // Pixel-to-tile conversion is a shift since TILE_PX is a power of two.
    assign tx       = xpos_i >> SH;
    assign ty       = ypos_i >> SH;
    assign idx_full = 32'(ty) * 32'(GRID_W) + 32'(tx);
    assign idx      = idx_full[AW-1:0];
    assign legal_o  = (idx_full < 32'(N)) ? tbl_q[idx] : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_q <= '0;
        end else if (we_i && (32'(waddr_i) < 32'(N))) begin
            tbl_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/maze_move_ctrl.sv
// Sprite movement controller: buffers a requested turn, commits it at tile
// centres when legal, reverses instantly off-centre, and wraps at edges.
module maze_move_ctrl
    import maze_pkg::*;
#(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int TILE_PX = 32,
    parameter int START_X = 0,
    parameter int START_Y = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    maze_move_if.slave bus
);
    localparam logic [POS_W-1:0] X_MAX  = POS_W'((GRID_W - 1) * TILE_PX);
    localparam logic [POS_W-1:0] Y_MAX  = POS_W'((GRID_H - 1) * TILE_PX);
    localparam logic [POS_W-1:0] MASK   = POS_W'(TILE_PX - 1);
    localparam logic [POS_W-1:0] X_INIT = POS_W'(START_X);
    localparam logic [POS_W-1:0] Y_INIT = POS_W'(START_Y);
    localparam logic [POS_W-1:0] ONE    = POS_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       dir_q, dir_d, pend_q, pend_d, pend_eff;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic [3:0]       legal;
    logic             center;

    maze_legal_tbl #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .TILE_PX (TILE_PX)
    ) u_tbl (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (bus.tbl_we),
        .waddr_i (bus.tbl_addr),
        .wdata_i (bus.tbl_data),
        .xpos_i  (x_q),
        .ypos_i  (y_q),
        .legal_o (legal)
    );

    assign center = ((x_q & MASK) == '0) && ((y_q & MASK) == '0);

    always_comb begin
        // A fresh one-hot request takes part in this cycle's decision.
        pend_eff = $onehot(bus.dir_req) ? bus.dir_req : pend_q;
        pend_d   = pend_eff;
        dir_d    = dir_q;
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        if (bus.tick) begin
            if (center) begin
                if ((pend_eff & legal) != 4'b0000) begin
                    dir_d  = pend_eff;
                    pend_d = DIR_NONE;
                end else if ((dir_q & legal) == 4'b0000) begin
                    dir_d = DIR_NONE;
                end
            end else if ((dir_q != DIR_NONE) && (pend_eff == dir_opposite(dir_q))) begin
                dir_d  = pend_eff;
                pend_d = DIR_NONE;
            end
            state_d = (dir_d != DIR_NONE) ? ST_MOVE : ST_STOP;
            case (dir_d)
                DIR_L:   x_d = (x_q == '0)    ? X_MAX : x_q - ONE;
                DIR_R:   x_d = (x_q == X_MAX) ? '0    : x_q + ONE;
                DIR_U:   y_d = (y_q == '0)    ? Y_MAX : y_q - ONE;
                DIR_D:   y_d = (y_q == Y_MAX) ? '0    : y_q + ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            dir_q   <= DIR_NONE;
            pend_q  <= DIR_NONE;
            x_q     <= X_INIT;
            y_q     <= Y_INIT;
        end else if (bus.start) begin
            state_q <= ST_STOP;
            dir_q   <= DIR_NONE;
            pend_q  <= DIR_NONE;
            x_q     <= X_INIT;
            y_q     <= Y_INIT;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign bus.xpos      = x_q;
    assign bus.ypos      = y_q;
    assign bus.cur_dir   = dir_q;
    assign bus.moving    = (state_q == ST_MOVE);
    assign bus.legal     = legal;
    assign bus.at_center = center;

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed and randomized checks of maze_move_ctrl against a pixel-level
// reference model (8x8 grid, 32-pixel tiles, start at 0,0).
module tb_maze_move_ctrl;
    localparam int GW   = 8;
    localparam int GH   = 8;
    localparam int TILE = 32;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    maze_move_if #(.GRID_W(GW), .GRID_H(GH)) bus ();

    maze_move_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .TILE_PX(TILE), .START_X(0), .START_Y(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: pixel position, direction vector bits, pending, table.
    int         mx, my;
    logic [3:0] mdir, mpend;
    logic [3:0] mtbl [GW*GH];

    function automatic int dxof(input logic [3:0] d);
        return (d == 4'b1000) ? -1 : (d == 4'b0100) ? 1 : 0;
    endfunction

    function automatic int dyof(input logic [3:0] d);
        return (d == 4'b0010) ? -1 : (d == 4'b0001) ? 1 : 0;
    endfunction

    function automatic logic [3:0] mlegal(input int x, input int y);
        return mtbl[(y / TILE) * GW + x / TILE];
    endfunction

    task automatic model_update();
        logic [3:0] req, lg;
        int nx, ny;
        if (!rst_n) begin
            mx = 0; my = 0; mdir = 0; mpend = 0;
            foreach (mtbl[i]) mtbl[i] = 4'b0000;
            return;
        end
        if (bus.start) begin
            mx = 0; my = 0; mdir = 0; mpend = 0;
        end else begin
            req   = ($countones(bus.dir_req) == 1) ? bus.dir_req : mpend;
            mpend = req;
            if (bus.tick) begin
                lg = mlegal(mx, my);
                if ((mx % TILE == 0) && (my % TILE == 0)) begin
                    if ((req & lg) != 0) begin
                        mdir = req; mpend = 0;
                    end else if ((mdir & lg) == 0) begin
                        mdir = 0;
                    end
                end else if (req != 0 && mdir != 0 && dxof(req) == -dxof(mdir)
                             && dyof(req) == -dyof(mdir)) begin
                    mdir = req; mpend = 0;
                end
                nx = mx + dxof(mdir);
                ny = my + dyof(mdir);
                if (nx < 0) nx = (GW - 1) * TILE;
                else if (dxof(mdir) == 1 && mx == (GW - 1) * TILE) nx = 0;
                if (ny < 0) ny = (GH - 1) * TILE;
                else if (dyof(mdir) == 1 && my == (GH - 1) * TILE) ny = 0;
                mx = nx; my = ny;
            end
        end
        if (bus.tbl_we) mtbl[bus.tbl_addr] = bus.tbl_data;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tick = 0; bus.dir_req = 0; bus.start = 0;
        bus.tbl_we = 0; bus.tbl_addr = 0; bus.tbl_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0; step();
        rst_n = 1;
    endtask

    task automatic wr(input int addr, input logic [3:0] data);
        bus.tbl_we = 1; bus.tbl_addr = 6'(addr); bus.tbl_data = data;
        step();
        bus.tbl_we = 0;
    endtask

    task automatic tk(input logic [3:0] req);
        bus.tick = 1; bus.dir_req = req;
        step();
        bus.tick = 0; bus.dir_req = 0;
    endtask

    task automatic test_reset();
        bus.tick = 1; bus.dir_req = 4'b0100;
        rst_n = 0; step(); step();
        idle_inputs();
        rst_n = 1;
        checks++; if (bus.xpos !== 10'd0 || bus.ypos !== 10'd0) begin errors++;
            $display("FAIL reset_pos got %0d,%0d want 0,0", bus.xpos, bus.ypos); end
        checks++; if (bus.cur_dir !== 4'b0000 || bus.moving !== 1'b0) begin errors++;
            $display("FAIL reset_dir got %b/%b want 0000/0", bus.cur_dir, bus.moving); end
        checks++; if (bus.legal !== 4'b0000 || bus.at_center !== 1'b1) begin errors++;
            $display("FAIL reset_legal got %b/%b want 0000/1", bus.legal, bus.at_center); end
    endtask

    task automatic test_basic_move();
        do_reset();
        wr(0, 4'b0100);
        tk(4'b0100);
        tk(4'b0000);
        tk(4'b0000);
        checks++; if (bus.xpos !== 10'd3 || bus.ypos !== 10'd0) begin errors++;
            $display("FAIL basic_pos got %0d,%0d want 3,0", bus.xpos, bus.ypos); end
        checks++; if (bus.cur_dir !== 4'b0100 || bus.moving !== 1'b1) begin errors++;
            $display("FAIL basic_dir got %b/%b want 0100/1", bus.cur_dir, bus.moving); end
        step();
        checks++; if (bus.xpos !== 10'd3 || bus.cur_dir !== 4'b0100) begin errors++;
            $display("FAIL no_tick_hold got %0d/%b want 3/0100", bus.xpos, bus.cur_dir); end
    endtask

    task automatic test_blocked_pending();
        do_reset();
        tk(4'b0100);
        checks++; if (bus.xpos !== 10'd0 || bus.moving !== 1'b0) begin errors++;
            $display("FAIL blocked got x=%0d mv=%b want 0/0", bus.xpos, bus.moving); end
        wr(0, 4'b0100);
        tk(4'b0000);
        checks++; if (bus.xpos !== 10'd1 || bus.cur_dir !== 4'b0100) begin errors++;
            $display("FAIL pending_held got %0d/%b want 1/0100", bus.xpos, bus.cur_dir); end
        // Multi-hot requests are dropped; direction must not change.
        tk(4'b1100);
        checks++; if (bus.xpos !== 10'd2 || bus.cur_dir !== 4'b0100) begin errors++;
            $display("FAIL multihot got %0d/%b want 2/0100", bus.xpos, bus.cur_dir); end
    endtask

    task automatic test_reversal();
        do_reset();
        wr(0, 4'b0100);
        tk(4'b0100);
        repeat (4) tk(4'b0000);
        tk(4'b1000);
        checks++; if (bus.xpos !== 10'd4 || bus.cur_dir !== 4'b1000) begin errors++;
            $display("FAIL reversal got %0d/%b want 4/1000", bus.xpos, bus.cur_dir); end
    endtask

    task automatic test_turn();
        do_reset();
        wr(0, 4'b0100);
        wr(1, 4'b0001);
        tk(4'b0100);
        tk(4'b0001);
        repeat (30) tk(4'b0000);
        checks++; if (bus.xpos !== 10'd32 || bus.legal !== 4'b0001 || bus.at_center !== 1'b1) begin
            errors++; $display("FAIL turn_arrive got %0d/%b/%b want 32/0001/1",
                               bus.xpos, bus.legal, bus.at_center); end
        tk(4'b0000);
        checks++; if (bus.xpos !== 10'd32 || bus.ypos !== 10'd1 || bus.cur_dir !== 4'b0001) begin
            errors++; $display("FAIL turn got %0d,%0d/%b want 32,1/0001",
                               bus.xpos, bus.ypos, bus.cur_dir); end
    endtask

    task automatic test_wrap();
        do_reset();
        wr(0, 4'b1000);
        tk(4'b1000);
        checks++; if (bus.xpos !== 10'd224 || bus.cur_dir !== 4'b1000) begin errors++;
            $display("FAIL wrap_left got %0d/%b want 224/1000", bus.xpos, bus.cur_dir); end
        wr(7, 4'b0100);
        tk(4'b0100);
        checks++; if (bus.xpos !== 10'd0 || bus.cur_dir !== 4'b0100) begin errors++;
            $display("FAIL wrap_right got %0d/%b want 0/0100", bus.xpos, bus.cur_dir); end
        do_reset();
        wr(0, 4'b0010);
        tk(4'b0010);
        checks++; if (bus.ypos !== 10'd224 || bus.xpos !== 10'd0) begin errors++;
            $display("FAIL wrap_up got %0d,%0d want 0,224", bus.xpos, bus.ypos); end
    endtask

    task automatic test_write_same_cycle();
        do_reset();
        bus.tbl_we = 1; bus.tbl_addr = 0; bus.tbl_data = 4'b0100;
        tk(4'b0100);
        bus.tbl_we = 0;
        checks++; if (bus.xpos !== 10'd0 || bus.moving !== 1'b0) begin errors++;
            $display("FAIL prewrite got %0d/%b want 0/0", bus.xpos, bus.moving); end
        tk(4'b0000);
        checks++; if (bus.xpos !== 10'd1) begin errors++;
            $display("FAIL postwrite got %0d want 1", bus.xpos); end
    endtask

    task automatic test_start_and_midreset();
        do_reset();
        wr(0, 4'b0100);
        tk(4'b0100);
        tk(4'b0000);
        bus.start = 1;
        tk(4'b0100);
        bus.start = 0;
        checks++; if (bus.xpos !== 10'd0 || bus.cur_dir !== 4'b0000 || bus.moving !== 1'b0) begin
            errors++; $display("FAIL start got %0d/%b/%b want 0/0000/0",
                               bus.xpos, bus.cur_dir, bus.moving); end
        checks++; if (bus.legal !== 4'b0100) begin errors++;
            $display("FAIL start_tbl got %b want 0100", bus.legal); end
        tk(4'b0100);
        tk(4'b0000);
        bus.tick = 1; bus.start = 1; bus.tbl_we = 1; bus.tbl_data = 4'b1111;
        rst_n = 0; step();
        rst_n = 1; idle_inputs();
        checks++; if (bus.xpos !== 10'd0 || bus.ypos !== 10'd0 || bus.moving !== 1'b0
                      || bus.legal !== 4'b0000) begin errors++;
            $display("FAIL midreset got %0d,%0d mv=%b lg=%b want 0,0 0 0000",
                     bus.xpos, bus.ypos, bus.moving, bus.legal); end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] exp_lg;
        do_reset();
        for (int a = 0; a < GW * GH; a++) wr(a, 4'($urandom_range(0, 15)));
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            bus.dir_req  = (r < 4) ? 4'b0000 : (r < 8) ? 4'(1 << (r - 4)) : 4'($urandom_range(0, 15));
            bus.tick     = ($urandom_range(0, 2) != 0);
            bus.tbl_we   = ($urandom_range(0, 7) == 0);
            bus.tbl_addr = 6'($urandom_range(0, GW * GH - 1));
            bus.tbl_data = 4'($urandom_range(0, 15));
            bus.start    = ($urandom_range(0, 299) == 0);
            step();
            exp_lg = mlegal(mx, my);
            checks++;
            if (bus.xpos !== 10'(mx) || bus.ypos !== 10'(my) || bus.cur_dir !== mdir
                || bus.moving !== (mdir != 0) || bus.legal !== exp_lg
                || bus.at_center !== ((mx % TILE == 0) && (my % TILE == 0))) begin
                errors++;
                $display("FAIL random[%0d] got x=%0d y=%0d d=%b mv=%b lg=%b c=%b want x=%0d y=%0d d=%b lg=%b",
                         n, bus.xpos, bus.ypos, bus.cur_dir, bus.moving, bus.legal,
                         bus.at_center, mx, my, mdir, exp_lg);
            end
        end
        idle_inputs();
    endtask

    initial begin
        clk = 0;
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_basic_move();
        test_blocked_pending();
        test_reversal();
        test_turn();
        test_wrap();
        test_write_same_cycle();
        test_start_and_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
